// File: rtl/mfcc_feature_streamer.sv
// MFCC feature streamer: captures 640-bit feature vectors into a
// two-slot ping-pong buffer and serialises them as a coefficient stream.
module mfcc_feature_streamer #(
  parameter int NUM_COEFFS  = 40,
  parameter int COEFF_WIDTH = 16,
  parameter int IDX_WIDTH   = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_COEFFS*COEFF_WIDTH-1:0] feature_in,
  input  logic                              feature_valid,
  output logic [COEFF_WIDTH-1:0]            coeff_out,
  output logic                              coeff_valid,
  input  logic                              coeff_ready,
  output logic                              coeff_last,
  output logic [IDX_WIDTH-1:0]              coeff_index,
  output logic [1:0]                        buf_count,
  output logic                              overflow,
  input  logic                              clear_overflow
);

  typedef enum logic {
    EMPTY,
    STREAM
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUM_COEFFS - 1);

  state_t                 state;
  logic [COEFF_WIDTH-1:0] slot [2][NUM_COEFFS];
  logic [1:0]             slot_valid;
  logic [1:0]             valid_nxt;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [IDX_WIDTH-1:0]   idx;

  logic streaming;
  logic fire;
  logic done;
  logic accept;
  logic drop;

  assign streaming = (state == STREAM);
  assign fire      = streaming && coeff_ready;
  assign done      = fire && (idx == LAST_IDX);

  // A slot freed by the final handshake is reusable in the same cycle.
  assign accept = feature_valid && (!slot_valid[wr_ptr] || done);
  assign drop   = feature_valid && !accept;

  always_comb begin
    valid_nxt = slot_valid;
    if (done)
      valid_nxt[rd_ptr] = 1'b0;
    if (accept)
      valid_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      slot_valid <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      idx        <= '0;
      overflow   <= 1'b0;
    end else begin
      slot_valid <= valid_nxt;

      if (accept)
        wr_ptr <= ~wr_ptr;

      if (fire) begin
        if (done) begin
          idx    <= '0;
          rd_ptr <= ~rd_ptr;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      unique case (state)
        EMPTY: begin
          if (accept)
            state <= STREAM;
        end
        STREAM: begin
          if (done && !valid_nxt[~rd_ptr])
            state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase

      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  // Payload storage carries no reset; validity lives in slot_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_COEFFS; k++)
        slot[wr_ptr][k] <=
          feature_in[k*COEFF_WIDTH +: COEFF_WIDTH];
    end
  end

  assign coeff_valid = streaming;
  assign coeff_index = idx;
  assign coeff_last  = streaming && (idx == LAST_IDX);
  assign coeff_out   = streaming ? slot[rd_ptr][idx] : '0;
  assign buf_count   = {slot_valid[0] & slot_valid[1],
                        slot_valid[0] ^ slot_valid[1]};

endmodule

// File: tb/tb_mfcc_feature_streamer.sv
// Scoreboard bench for mfcc_feature_streamer: expected coefficients
// are queued at capture time and checked on each handshake.
module tb_mfcc_feature_streamer;

  localparam int NC = 40;
  localparam int CW = 16;
  localparam int IW = 6;

  typedef struct packed {
    logic [CW-1:0] val;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC*CW-1:0] feature_in = '0;
  logic             feature_valid = 1'b0;
  logic [CW-1:0]    coeff_out;
  logic             coeff_valid;
  logic             coeff_ready = 1'b0;
  logic             coeff_last;
  logic [IW-1:0]    coeff_index;
  logic [1:0]       buf_count;
  logic             overflow;
  logic             clear_overflow = 1'b0;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_xfer = 0;

  mfcc_feature_streamer #(
    .NUM_COEFFS (NC),
    .COEFF_WIDTH(CW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .feature_in    (feature_in),
    .feature_valid (feature_valid),
    .coeff_out     (coeff_out),
    .coeff_valid   (coeff_valid),
    .coeff_ready   (coeff_ready),
    .coeff_last    (coeff_last),
    .coeff_index   (coeff_index),
    .buf_count     (buf_count),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor and stall-stability checker.
  logic          stall_prev = 1'b0;
  logic [CW-1:0] held_out;
  logic [IW-1:0] held_idx;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && coeff_valid) begin
        check("stall_out", 32'(coeff_out), 32'(held_out));
        check("stall_idx", 32'(coeff_index), 32'(held_idx));
      end
      if (coeff_valid && coeff_ready) begin
        n_xfer++;
        if (q.size() == 0) begin
          check("unexpected", 32'(coeff_out), 32'hffff_ffff);
        end else begin
          e = q.pop_front();
          check("data", 32'(coeff_out), 32'(e.val));
          check("index", 32'(coeff_index), 32'(e.idx));
          check("last", 32'(coeff_last), 32'(e.last));
        end
      end
      stall_prev = coeff_valid && !coeff_ready;
      held_out   = coeff_out;
      held_idx   = coeff_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [CW-1:0] base,
                          input bit push);
    exp_t e;
    for (int k = 0; k < NC; k++)
      feature_in[k*CW +: CW] = base + CW'(k);
    feature_valid = 1'b1;
    if (push) begin
      for (int k = 0; k < NC; k++) begin
        e.val  = base + CW'(k);
        e.idx  = IW'(k);
        e.last = (k == NC - 1);
        q.push_back(e);
      end
    end
    tick();
    feature_valid = 1'b0;
  endtask

  // mode 0: ready held; mode 1: ready pattern 1,0,0,1
  task automatic drain(input int mode, output int cyc);
    cyc = 0;
    while (q.size() != 0 && cyc < 1000) begin
      if (mode == 1)
        coeff_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      tick();
      cyc++;
    end
    if (q.size() != 0)
      check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic run_to_idx(input int target);
    int n;
    n = 0;
    while (coeff_index != IW'(target) && n < 200) begin
      tick();
      n++;
    end
    check("reach_idx", 32'(coeff_index), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int cyc;

    #1;
    check("rst_valid", 32'(coeff_valid), 32'd0);
    check("rst_last", 32'(coeff_last), 32'd0);
    check("rst_index", 32'(coeff_index), 32'd0);
    check("rst_out", 32'(coeff_out), 32'd0);
    check("rst_count", 32'(buf_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single vector, ready held high
    coeff_ready = 1'b1;
    n_xfer = 0;
    send_vec(16'h0100, 1'b1);
    check("lat_valid", 32'(coeff_valid), 32'd1);
    check("lat_out", 32'(coeff_out), 32'h0100);
    drain(0, cyc);
    check("t1_cycles", 32'(cyc), 32'd40);
    check("t1_xfers", 32'(n_xfer), 32'd40);
    check("t1_valid_end", 32'(coeff_valid), 32'd0);
    check("t1_count_end", 32'(buf_count), 32'd0);

    // backpressure
    coeff_ready = 1'b1;
    n_xfer = 0;
    send_vec(16'h2200, 1'b1);
    drain(1, cyc);
    coeff_ready = 1'b1;
    tick();
    check("t2_xfers", 32'(n_xfer), 32'd40);
    check("t2_valid_end", 32'(coeff_valid), 32'd0);

    // back-to-back vectors, zero bubble
    n_xfer = 0;
    send_vec(16'hA000, 1'b1);
    repeat (4) tick();
    send_vec(16'hB000, 1'b1);
    check("t3_count2", 32'(buf_count), 32'd2);
    drain(0, cyc);
    check("t3_cycles", 32'(cyc + 5), 32'd80);
    check("t3_xfers", 32'(n_xfer), 32'd80);
    check("t3_count_end", 32'(buf_count), 32'd0);

    // overflow: C dropped
    coeff_ready = 1'b0;
    n_xfer = 0;
    send_vec(16'hA000, 1'b1);
    send_vec(16'hB000, 1'b1);
    check("t4_ovf0", 32'(overflow), 32'd0);
    send_vec(16'hC000, 1'b0);
    check("t4_count", 32'(buf_count), 32'd2);
    check("t4_ovf", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t4_clear", 32'(overflow), 32'd0);
    coeff_ready = 1'b1;
    drain(0, cyc);
    tick();
    check("t4_xfers", 32'(n_xfer), 32'd80);
    check("t4_count_end", 32'(buf_count), 32'd0);

    // capture coincides with final transfer of A
    coeff_ready = 1'b0;
    n_xfer = 0;
    send_vec(16'hA000, 1'b1);
    send_vec(16'hB000, 1'b1);
    coeff_ready = 1'b1;
    run_to_idx(NC - 1);
    check("t5_last", 32'(coeff_last), 32'd1);
    send_vec(16'hC000, 1'b1);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_count", 32'(buf_count), 32'd2);
    check("t5_index", 32'(coeff_index), 32'd0);
    check("t5_outB", 32'(coeff_out), 32'hB000);
    drain(0, cyc);
    tick();
    check("t5_xfers", 32'(n_xfer), 32'd120);

    // async reset mid-stream with B buffered and overflow set
    coeff_ready = 1'b0;
    send_vec(16'hA000, 1'b1);
    send_vec(16'hB000, 1'b1);
    send_vec(16'hC000, 1'b0);
    check("t6_ovf_pre", 32'(overflow), 32'd1);
    coeff_ready = 1'b1;
    run_to_idx(17);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("t6_rst_valid", 32'(coeff_valid), 32'd0);
    check("t6_rst_count", 32'(buf_count), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_index", 32'(coeff_index), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle", 32'(coeff_valid), 32'd0);
    n_xfer = 0;
    send_vec(16'hD000, 1'b1);
    check("t6_d_index", 32'(coeff_index), 32'd0);
    check("t6_d_out", 32'(coeff_out), 32'hD000);
    drain(0, cyc);
    tick();
    check("t6_xfers", 32'(n_xfer), 32'd40);
    check("t6_valid_end", 32'(coeff_valid), 32'd0);
    check("t6_count_end", 32'(buf_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mfcc_feature_streamer.md
Name: mfcc_feature_streamer

Overview:
- Consumer side of the MFCC accelerator's feature interface.
- Captures each 640-bit feature vector presented with its one-cycle valid strobe into a 2-entry ping-pong buffer.
- Serialises each vector as 40 signed 16-bit coefficients over a valid/ready stream to the downstream classifier, with last-flag framing and overflow detection.

Parameters:
- NUM_COEFFS, 40, coefficients per feature vector.
- COEFF_WIDTH, 16, bits per coefficient.
- IDX_WIDTH, 6, width of the coefficient index; must satisfy 2^IDX_WIDTH >= NUM_COEFFS.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- feature_in  input  NUM_COEFFS*COEFF_WIDTH  packed vector; coefficient k is in bits [k*COEFF_WIDTH +: COEFF_WIDTH].
- feature_valid  input  1  single-cycle strobe; feature_in is sampled on that edge.
- coeff_out  output  COEFF_WIDTH  current coefficient.
- coeff_valid  output  1  coeff_out is valid.
- coeff_ready  input  1  downstream accepts; a transfer occurs when coeff_valid && coeff_ready.
- coeff_last  output  1  high with coefficient NUM_COEFFS-1.
- coeff_index  output  IDX_WIDTH  index of coeff_out within its vector.
- buf_count  output  2  number of vectors held: 0, 1 or 2.
- overflow  output  1  sticky; set when a vector is dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async): buffers' valid bits = 0, wr_ptr = rd_ptr = 0, read index = 0, buf_count = 0, overflow = 0.
- Output values during reset: coeff_valid = 0, coeff_last = 0, coeff_index = 0, coeff_out = 0.
- Reset mid-stream discards all buffered data. There is no partial resume.

Storage:
- Two slots of NUM_COEFFS*COEFF_WIDTH bits each.
- wr_ptr and rd_ptr are 1-bit and toggle after each write and each vector completion respectively.

Capture:
- On feature_valid with buf_count < 2: write feature_in to slot[wr_ptr], toggle wr_ptr, increment buf_count.
- On feature_valid with buf_count == 2: drop the vector, set overflow = 1, and leave buffers and pointers unchanged.
- Exception: if the final transfer (coeff_last handshake) occurs in the same cycle as that feature_valid, the slot is treated as freed first. The vector is accepted and no overflow is raised.

Read FSM: states EMPTY and STREAM.
- EMPTY: coeff_valid = 0. Go to STREAM when buf_count becomes non-zero.
- STREAM: coeff_valid = 1, coeff_out = slot[rd_ptr][index*COEFF_WIDTH +: COEFF_WIDTH], coeff_index = index, coeff_last = (index == NUM_COEFFS-1).
- Output timing:
  - Outputs are driven from registered state only (buffer registers, index, rd_ptr). There is no combinational path from coeff_ready or feature_in to any output.
  - While coeff_valid && !coeff_ready, coeff_out, coeff_index and coeff_last hold stable.
- Handshake with index < NUM_COEFFS-1: index increments.
- Handshake with the last coefficient: index = 0, rd_ptr toggles, buf_count decrements. Stay in STREAM if the other slot is full (zero bubble between vectors); otherwise go to EMPTY.

Timing and counting:
- Latency: feature_valid at edge N with an empty buffer gives coeff_valid = 1 with coefficient 0 after edge N (first cycle after capture).
- Best-case throughput is one coefficient per cycle, i.e. 40 cycles per vector.
- Simultaneous capture and final read: buf_count is unchanged (+1-1).

Overflow flag:
- clear_overflow clears overflow.
- If clear_overflow and a drop happen in the same cycle, set wins and overflow = 1.

Data handling:
- Coefficients pass through bit-exact; the block performs no arithmetic or sign changes.

Test Plan:
- Single vector with coeff_ready held at 1. feature_in[k] = 16'h0100+k, k = 0..39 -> coeff_valid rises the cycle after capture. Outputs appear in order 16'h0100..16'h0127 on 40 consecutive cycles, coeff_index 0..39, coeff_last only on 16'h0127, then coeff_valid = 0 and buf_count = 0.
- Backpressure: coeff_ready toggles 1,0,0,1 repeatedly -> no coefficient lost or duplicated. coeff_out and coeff_index are stable on every stalled cycle, and 40 transfers complete in order.
- Back-to-back vectors A (16'hA000+k) then B (16'hB000+k), 5 cycles apart, coeff_ready = 1 -> buf_count reaches 2. 16'hB000 follows 16'hA027 on the very next cycle, with 80 transfers total.
- Overflow: coeff_ready = 0, three vectors A, B, C -> buf_count = 2, overflow = 1. The stream then delivers A then B only, and C is never seen. clear_overflow for one cycle -> overflow = 0.
- Edge collision: buffer full, the last transfer of A coincides with feature_valid for C -> overflow stays 0, buf_count stays 2, and the order is B then C.
- Async reset asserted at coefficient index 17 of A with B buffered -> coeff_valid, buf_count and overflow go to 0 immediately. After release, a new vector D streams from index 0 with no A or B data.
